// File: rtl/mux_pkg.sv
// Shared types and constants for the 2:1 stream mux arbiter
// and the mux datapath it drives.
package mux_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mux_out_reg.sv
// Single-entry registered output slot.
// Carries data, last and the owning channel select.
module mux_out_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             dlast,
  input  logic             dsel,
  input  logic             out_ready,
  output logic             space,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             sel
);

  assign space = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      sel       <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= din;
      out_last  <= dlast;
      sel       <= dsel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_stream_arb.sv
// Two-input round-robin packet arbiter feeding the 2:1 mux.
// Ownership is held from first beat to last beat.
module mux_stream_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  input  logic             i0_last,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  input  logic             i1_last,
  output logic             i1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  arb_state_e state;
  logic       prio;
  logic       space;
  logic       g0, g1;
  logic       x0, x1;
  logic       load;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (state)
      IDLE: begin
        if (i0_valid && i1_valid) begin
          g0 = !prio;
          g1 = prio;
        end else begin
          g0 = i0_valid;
          g1 = i1_valid;
        end
      end
      OWN0:    g0 = 1'b1;
      OWN1:    g1 = 1'b1;
      default: ;
    endcase
  end

  // valid never looks at ready, so the grant path forms no loop
  assign i0_ready = !rst && space && g0;
  assign i1_ready = !rst && space && g1;

  assign x0   = i0_valid && i0_ready;
  assign x1   = i1_valid && i1_ready;
  assign load = x0 || x1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (x0) begin
            if (i0_last) prio  <= 1'b1;
            else         state <= OWN0;
          end else if (x1) begin
            if (i1_last) prio  <= 1'b0;
            else         state <= OWN1;
          end
        end
        OWN0: begin
          if (x0 && i0_last) begin
            state <= IDLE;
            prio  <= 1'b1;
          end
        end
        OWN1: begin
          if (x1 && i1_last) begin
            state <= IDLE;
            prio  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mux_out_reg #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      (x1 ? i1_data : i0_data),
    .dlast    (x1 ? i1_last : i0_last),
    .dsel     (x1),
    .out_ready(out_ready),
    .space    (space),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .sel      (sel)
  );

endmodule

// File: tb/tb_mux_stream_arb.sv
// Directed bench for mux_stream_arb: one task per scenario,
// output beats collected by a monitor into a queue.
module tb_mux_stream_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i0_valid = 1'b0;
  logic [7:0] i0_data = '0;
  logic       i0_last = 1'b0;
  logic       i0_ready;
  logic       i1_valid = 1'b0;
  logic [7:0] i1_data = '0;
  logic       i1_last = 1'b0;
  logic       i1_ready;
  logic       sel;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b1;

  int total = 0;
  int bad = 0;

  // {sel, last, data}
  logic [9:0] q[$];

  mux_stream_arb #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .i0_valid (i0_valid),
    .i0_data  (i0_data),
    .i0_last  (i0_last),
    .i0_ready (i0_ready),
    .i1_valid (i1_valid),
    .i1_data  (i1_data),
    .i1_last  (i1_last),
    .i1_ready (i1_ready),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) q.push_back({sel, out_last, out_data});
    total++;
    if (i0_ready && i1_ready) begin
      bad++;
      $display("FAIL both_ready t=%0t i0_ready=%b i1_ready=%b required one low",
               $time, i0_ready, i1_ready);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    i0_valid = 1'b1; i0_data = 8'h3C; i0_last = 1'b1;
    i1_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_data, out_last, sel, i0_ready, i1_ready} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outs got v=%b d=%h l=%b s=%b r0=%b r1=%b required all 0",
               out_valid, out_data, out_last, sel, i0_ready, i1_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (i0_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got r0=%b v=%b required r0=1 v=0", i0_ready, out_valid);
    end
    step();
    i0_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || sel !== 1'b0 || out_last !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_beat got v=%b d=%h s=%b l=%b required v=1 d=3c s=0 l=1",
               out_valid, out_data, sel, out_last);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_drain got v=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int k0, k1, cyc;
    logic h0, h1;
    logic [9:0] e;
    logic [7:0] base;
    do_reset();
    q.delete();
    k0 = 0; k1 = 0; cyc = 0;
    i0_last = 1'b1; i1_last = 1'b1;
    while ((k0 < 4 || k1 < 4) && cyc < 20) begin
      i0_valid = (k0 < 4); i0_data = 8'(8'hA0 + k0);
      i1_valid = (k1 < 4); i1_data = 8'(8'hB0 + k1);
      #1;
      h0 = i0_valid && i0_ready;
      h1 = i1_valid && i1_ready;
      step();
      k0 += int'(h0);
      k1 += int'(h1);
      cyc++;
    end
    i0_valid = 1'b0; i1_valid = 1'b0;
    step(); step();
    total++;
    if (cyc !== 8) begin
      bad++;
      $display("FAIL b2b_cycles got %0d required 8", cyc);
    end
    total++;
    if (q.size() !== 8) begin
      bad++;
      $display("FAIL b2b_count got %0d required 8", q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        base = (i % 2 == 0) ? 8'hA0 : 8'hB0;
        e = {1'(i % 2), 1'b1, 8'(base + i / 2)};
        total++;
        if (q[i] !== e) begin
          bad++;
          $display("FAIL b2b_beat%0d got %h required %h", i, q[i], e);
        end
      end
    end
  endtask

  task automatic test_lock();
    logic [9:0] e[4];
    e[0] = {1'b1, 1'b0, 8'h11};
    e[1] = {1'b1, 1'b0, 8'h12};
    e[2] = {1'b1, 1'b1, 8'h13};
    e[3] = {1'b0, 1'b1, 8'h77};
    q.delete();
    out_ready = 1'b1;
    i1_valid = 1'b1; i1_data = 8'h11; i1_last = 1'b0;
    step();
    i1_data = 8'h12;
    i0_valid = 1'b1; i0_data = 8'h77; i0_last = 1'b1;
    #1;
    total++;
    if (i0_ready !== 1'b0 || i1_ready !== 1'b1) begin
      bad++;
      $display("FAIL lock_beat2 got r0=%b r1=%b required r0=0 r1=1", i0_ready, i1_ready);
    end
    step();
    i1_data = 8'h13; i1_last = 1'b1;
    #1;
    total++;
    if (i0_ready !== 1'b0) begin
      bad++;
      $display("FAIL lock_beat3 got r0=%b required 0", i0_ready);
    end
    step();
    i1_valid = 1'b0;
    #1;
    total++;
    if (i0_ready !== 1'b1) begin
      bad++;
      $display("FAIL lock_handover got r0=%b required 1", i0_ready);
    end
    step();
    i0_valid = 1'b0;
    step(); step();
    total++;
    if (q.size() !== 4) begin
      bad++;
      $display("FAIL lock_count got %0d required 4", q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q[i] !== e[i]) begin
          bad++;
          $display("FAIL lock_beat%0d got %h required %h", i, q[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    q.delete();
    out_ready = 1'b1;
    i0_valid = 1'b1; i0_data = 8'h5C; i0_last = 1'b1;
    step();
    i0_valid = 1'b0;
    i1_valid = 1'b1; i1_data = 8'h66; i1_last = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h5C || sel !== 1'b0 ||
          out_last !== 1'b1 || i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%b d=%h s=%b l=%b r0=%b r1=%b required 1 5c 0 1 0 0",
                 c, out_valid, out_data, sel, out_last, i0_ready, i1_ready);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (i1_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_resume_ready got r1=%b required 1", i1_ready);
    end
    step();
    i1_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h66 || sel !== 1'b1) begin
      bad++;
      $display("FAIL bp_next got v=%b d=%h s=%b required 1 66 1", out_valid, out_data, sel);
    end
    step();
    total++;
    if (q.size() !== 2 || q[0] !== {2'b01, 8'h5C} || q[1] !== {2'b11, 8'h66}) begin
      bad++;
      $display("FAIL bp_order got size=%0d q0=%h q1=%h required 2 15c 366",
               q.size(), q.size() > 0 ? q[0] : 10'h0, q.size() > 1 ? q[1] : 10'h0);
    end
  endtask

  task automatic test_gap_lock();
    q.delete();
    out_ready = 1'b1;
    i0_valid = 1'b1; i0_data = 8'h21; i0_last = 1'b0;
    i1_valid = 1'b1; i1_data = 8'h99; i1_last = 1'b1;
    #1;
    total++;
    if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
      bad++;
      $display("FAIL gap_grant got r0=%b r1=%b required 1 0", i0_ready, i1_ready);
    end
    step();
    i0_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (i1_ready !== 1'b0) begin
        bad++;
        $display("FAIL gap_hold%0d got r1=%b required 0", c, i1_ready);
      end
      step();
    end
    i0_valid = 1'b1; i0_data = 8'h22; i0_last = 1'b1;
    #1;
    total++;
    if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
      bad++;
      $display("FAIL gap_last got r0=%b r1=%b required 1 0", i0_ready, i1_ready);
    end
    step();
    i0_valid = 1'b0;
    #1;
    total++;
    if (i1_ready !== 1'b1) begin
      bad++;
      $display("FAIL gap_switch got r1=%b required 1", i1_ready);
    end
    step();
    i1_valid = 1'b0;
    step(); step();
    total++;
    if (q.size() !== 3 || q[0] !== {2'b00, 8'h21} ||
        q[1] !== {2'b01, 8'h22} || q[2] !== {2'b11, 8'h99}) begin
      bad++;
      $display("FAIL gap_order got size=%0d required 3 beats 021 122 399", q.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    i0_valid = 1'b0;
    i1_valid = 1'b1; i1_data = 8'h44; i1_last = 1'b0;
    step();
    i1_data = 8'h45;
    total++;
    if (out_valid !== 1'b1 || sel !== 1'b1) begin
      bad++;
      $display("FAIL mid_setup got v=%b s=%b required 1 1", out_valid, sel);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== 1'b0 || i1_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_clear got v=%b d=%h s=%b r1=%b required 0 00 0 0",
               out_valid, out_data, sel, i1_ready);
    end
    i1_last = 1'b1;
    i0_valid = 1'b1; i0_data = 8'h55; i0_last = 1'b1;
    step();
    q.delete();
    rst = 1'b0;
    #1;
    total++;
    if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_prio got r0=%b r1=%b required 1 0", i0_ready, i1_ready);
    end
    step();
    i0_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h55 || sel !== 1'b0) begin
      bad++;
      $display("FAIL mid_beat got v=%b d=%h s=%b required 1 55 0", out_valid, out_data, sel);
    end
    step();
    i1_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lock();
    test_backpressure();
    test_gap_lock();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
